// File: rtl/esaxi_wr.sv
// -----------------------------------------------------------------------------
// esaxi_wr : AXI4 slave write-channel front end for the eMesh bridge.
//
// Accepts one AXI write burst at a time on the AW/W/B channels and emits one
// 104-bit eMesh write packet for every accepted data beat. The packet sits in
// a single output register that can be drained and refilled in the same cycle.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   s_axi_aw*         write address channel (id, addr, len, size, burst)
//   s_axi_w*          write data channel (wstrb is ignored; the address picks
//                     the lane)
//   s_axi_b*          write response channel (always OKAY)
//   wr_access         eMesh packet valid
//   wr_packet         eMesh packet {srcaddr, data, dstaddr, ctrlmode,
//                     datamode, write}
//   wr_wait           eMesh backpressure; packet is held while high
// -----------------------------------------------------------------------------
module esaxi_wr #(
    parameter int unsigned IDW      = 12,
    parameter logic [4:0]  CTRLMODE = 5'b00000,
    parameter logic [31:0] SRCADDR  = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [IDW-1:0] s_axi_awid,
    input  logic [31:0]    s_axi_awaddr,
    input  logic [7:0]     s_axi_awlen,
    input  logic [2:0]     s_axi_awsize,
    input  logic [1:0]     s_axi_awburst,
    input  logic           s_axi_awvalid,
    output logic           s_axi_awready,
    input  logic [63:0]    s_axi_wdata,
    input  logic [7:0]     s_axi_wstrb,
    input  logic           s_axi_wlast,
    input  logic           s_axi_wvalid,
    output logic           s_axi_wready,
    output logic [IDW-1:0] s_axi_bid,
    output logic [1:0]     s_axi_bresp,
    output logic           s_axi_bvalid,
    input  logic           s_axi_bready,
    output logic           wr_access,
    output logic [103:0]   wr_packet,
    input  logic           wr_wait
);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;

    state_t         state, state_nxt;
    logic [IDW-1:0] id_q;
    logic [31:0]    addr_q;
    logic [7:0]     len_q;
    logic [7:0]     beat_cnt;
    logic [1:0]     burst_q;
    logic [1:0]     size_q;

    logic           beat;
    logic [31:0]    lane_data;
    logic [31:0]    src_data;
    logic [31:0]    addr_nxt;
    logic [103:0]   packet_nxt;

    // Strobes are not needed: the beat address selects the byte lane.
    logic unused;
    assign unused = ^s_axi_wstrb;

    assign s_axi_bid   = id_q;
    assign s_axi_bresp = 2'b00;

    // NOTE: every signal driven here gets a default first so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        beat          = 1'b0;
        case (state)
            IDLE: begin
                s_axi_awready = 1'b1;
                if (s_axi_awvalid) state_nxt = DATA;
            end
            DATA: begin
                // Output register is free, or being drained this cycle.
                s_axi_wready = ~wr_access | ~wr_wait;
                beat         = s_axi_wvalid & s_axi_wready;
                // Whichever comes first, wlast or len+1 beats, ends the burst.
                if (beat && (s_axi_wlast || beat_cnt == len_q)) state_nxt = RESP;
            end
            RESP: begin
                // Hold the response until the final packet has left.
                s_axi_bvalid = ~wr_access | ~wr_wait;
                if (s_axi_bvalid && s_axi_bready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Lane select and packet assembly for the current beat.
    always_comb begin
        lane_data = 32'd0;
        case (size_q)
            2'd0:    lane_data = {24'd0, s_axi_wdata[{addr_q[2:0], 3'b000} +: 8]};
            2'd1:    lane_data = {16'd0, s_axi_wdata[{addr_q[2:1], 4'b0000} +: 16]};
            2'd2:    lane_data = s_axi_wdata[{addr_q[2], 5'b00000} +: 32];
            default: lane_data = s_axi_wdata[31:0];
        endcase
        src_data   = (size_q == 2'd3) ? s_axi_wdata[63:32] : SRCADDR;
        packet_nxt = {src_data, lane_data, addr_q, CTRLMODE, size_q, 1'b1};
        // WRAP is handled as INCR; the adder wraps modulo 2^32.
        addr_nxt   = (burst_q == BURST_FIXED) ? addr_q : addr_q + (32'd1 << size_q);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_cnt  <= '0;
            burst_q   <= '0;
            size_q    <= '0;
            wr_access <= 1'b0;
            wr_packet <= '0;
        end else begin
            state <= state_nxt;
            if (s_axi_awvalid && s_axi_awready) begin
                id_q     <= s_axi_awid;
                addr_q   <= s_axi_awaddr;
                len_q    <= s_axi_awlen;
                burst_q  <= s_axi_awburst;
                size_q   <= (s_axi_awsize > 3'd3) ? 2'd3 : s_axi_awsize[1:0];
                beat_cnt <= '0;
            end
            if (beat) begin
                addr_q    <= addr_nxt;
                beat_cnt  <= beat_cnt + 8'd1;
                wr_access <= 1'b1;
                wr_packet <= packet_nxt;
            end else if (!wr_wait) begin
                wr_access <= 1'b0;
            end
        end
    end

endmodule

// File: doc/esaxi_wr.md
Name: esaxi_wr

Overview:
- AXI4 slave write-channel front end: accepts AXI write bursts (AW, W, B) and emits one 104-bit eMesh write packet per data beat.
- Counterpart of the eMesh-to-AXI write master; sits at the AXI side of the eMesh bridge and feeds the mesh transmit path.
- Only one burst is in flight at a time.

Parameters:
- IDW, 12, AXI ID width for awid and bid.
- CTRLMODE, 5'b00000, constant value placed in packet ctrlmode field.
- SRCADDR, 32'h0000_0000, source address for non-doubleword packets.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- s_axi_awid  in  IDW  write address ID.
- s_axi_awaddr  in  32  burst start address.
- s_axi_awlen  in  8  beats minus 1.
- s_axi_awsize  in  3  log2 bytes per beat.
- s_axi_awburst  in  2  burst type.
- s_axi_awvalid  in  1  address valid.
- s_axi_awready  out  1  address accepted.
- s_axi_wdata  in  64  write data.
- s_axi_wstrb  in  8  byte strobes (ignored; lane selected by address).
- s_axi_wlast  in  1  last beat.
- s_axi_wvalid  in  1  data valid.
- s_axi_wready  out  1  data accepted.
- s_axi_bid  out  IDW  response ID.
- s_axi_bresp  out  2  response, always 2'b00 (OKAY).
- s_axi_bvalid  out  1  response valid.
- s_axi_bready  in  1  response accepted.
- wr_access  out  1  eMesh packet valid.
- wr_packet  out  104  eMesh packet.
- wr_wait  in  1  eMesh backpressure; packet held while high.

Behaviour:
- Reset values:
  - awready=1, wready=0, bvalid=0, bid=0, bresp=0.
  - wr_access=0, wr_packet=0.
  - State = IDLE.
- Reset is asynchronous and may assert mid-burst: the burst is abandoned and no B response is issued.

State machine:
- IDLE:
  - awready=1.
  - On awvalid&awready: latch id, addr, len, burst, and size (sizes above 3 are clamped to 3).
  - Go to DATA next cycle.
- DATA:
  - awready=0.
  - wready = ~wr_access | ~wr_wait.
  - Each wvalid&wready beat loads the output register: wr_access=1 on the next cycle.
  - Beat counter increments on each beat.
  - Beat with wlast=1, or beat count reaching len+1, whichever comes first: go to RESP.
  - A mismatched wlast does not stall the block.
- RESP:
  - bvalid=1, bid=latched id, bresp=OKAY.
  - bvalid asserts only after the final packet has been accepted (wr_access=0 or ~wr_wait).
  - On bvalid&bready: go to IDLE and set awready=1 the following cycle.

Output register:
- wr_access clears when ~wr_wait and no new beat is accepted in the same cycle.
- wr_packet is stable while wr_access&wr_wait.
- Accept and drain in the same cycle gives back-to-back packets: throughput is 1 beat per cycle while wr_wait=0.
- Latency is 1 cycle from W handshake to wr_access.

Packet format:
- [0] write=1.
- [2:1] datamode = size (00 byte, 01 half, 10 word, 11 double).
- [7:3] CTRLMODE.
- [39:8] dstaddr = current beat address.
- [71:40] data: wdata lane selected by addr[2:0], zero-extended; for size 3 this is wdata[31:0].
- [103:72] srcaddr: wdata[63:32] if size 3, else SRCADDR.

Address generation:
- INCR and WRAP: address += (1<<size) after each beat, 32-bit wrap-around modulo 2^32.
- WRAP is treated as INCR (unsupported, documented).
- FIXED: address constant.
- No 4 KB boundary checks.

Lane select:
- byte: wdata[8*addr[2:0] +: 8].
- half: wdata[16*addr[2:1] +: 16].
- word: wdata[32*addr[2] +: 32].

Test Plan:
- Single write: awaddr=0x8000_0004, size=2, len=0, wdata=0x1122334455667788, wr_wait=0 -> one packet, dstaddr=0x80000004, data=0x11223344, datamode=10; bvalid one cycle after packet drains; bid=awid.
- INCR burst: len=3, size=3, addr=0x100 -> 4 packets with dstaddr 0x100/0x108/0x110/0x118, srcaddr=wdata[63:32], on consecutive cycles with no bubbles.
- Backpressure: wr_wait high for 5 cycles during beat 2 -> wready=0 and wr_packet stable for those 5 cycles; no beat lost or duplicated.
- FIXED byte burst: addr=0x203, len=2, size=0 -> 3 packets, all dstaddr=0x203, data=wdata[31:24], datamode=00.
- Wrap-around: addr=0xFFFF_FFF8, size=3, len=1 -> dstaddr 0xFFFFFFF8 then 0x00000000.
- Reset mid-burst: assert rst after beat 1 of 4 -> wr_access=0, bvalid=0, awready=1 immediately; next burst completes normally.
